// File: rtl/eth_header_serializer.sv
// eth_header_serializer
//   Streams the 14-byte Ethernet II header (dest MAC, src MAC, EtherType) as OUT_W-bit
//   beats, with the 7x0x55 + 0xD5 preamble/SFD ahead of it when PREAMBLE=1. Bytes go
//   out first-to-last, and the bits of each byte go out LSB first. A valid/ready
//   handshake applies backpressure. A one-cycle done pulse follows the last beat.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      send request, sampled only while idle
//   dest_mac_i   destination MAC, [47:40] sent first; captured on start
//   src_mac_i    source MAC, captured on start
//   ethertype_i  EtherType, [15:8] sent first; captured on start
//   axior_i      downstream ready
//   axiov_o      beat valid
//   axiod_o      beat data (reads 0 when not valid)
//   axiolast_o   marks the final header beat
//   busy_o       high from start acceptance until the last beat is accepted
//   done_o       one-cycle pulse after the last beat is accepted
module eth_header_serializer #(
  parameter int unsigned OUT_W    = 2,
  parameter bit          PREAMBLE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [47:0]      dest_mac_i,
  input  logic [47:0]      src_mac_i,
  input  logic [15:0]      ethertype_i,
  input  logic             axior_i,
  output logic             axiov_o,
  output logic [OUT_W-1:0] axiod_o,
  output logic             axiolast_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned Bpb      = 8 / OUT_W;
  localparam int unsigned LogBpb   = $clog2(Bpb);
  localparam int unsigned NumBytes = PREAMBLE ? 22 : 14;
  localparam int unsigned NumBeats = NumBytes * Bpb;
  // Sized for the worst case (OUT_W=1 with preamble: 176 beats).
  localparam int unsigned CntW     = 8;

  localparam logic [CntW-1:0] LastIdx = CntW'(NumBeats - 1);
  localparam logic [CntW-1:0] PreEnd  = CntW'(8 * Bpb);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPre  = 2'd1;
  localparam logic [1:0] StHdr  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [111:0]     hdr_q, hdr_d;
  logic             axiov_q, axiov_d;
  logic [OUT_W-1:0] axiod_q, axiod_d;
  logic             axiolast_q, axiolast_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  // Beat number idx of the whole stream, taken from the packed header {dest, src, type}.
  function automatic logic [OUT_W-1:0] beat_of(input logic [111:0] hdr,
                                               input logic [CntW-1:0] idx);
    int unsigned byte_idx;
    int unsigned hb;
    int unsigned k;
    logic [7:0]  b;
    byte_idx = int'(idx) >> LogBpb;
    k        = int'(idx) % Bpb;
    if (PREAMBLE && byte_idx < 8) begin
      b = (byte_idx == 7) ? 8'hD5 : 8'h55;
    end else begin
      hb = PREAMBLE ? byte_idx - 8 : byte_idx;
      b  = hdr[(13 - hb) * 8 +: 8];
    end
    return b[k * OUT_W +: OUT_W];
  endfunction

  assign accept  = axiov_q & axior_i;
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    axiov_d    = axiov_q;
    axiod_d    = axiod_q;
    axiolast_d = axiolast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          hdr_d      = {dest_mac_i, src_mac_i, ethertype_i};
          cnt_d      = '0;
          state_d    = PREAMBLE ? StPre : StHdr;
          axiov_d    = 1'b1;
          busy_d     = 1'b1;
          // Beat 0 comes straight from the inputs so it is valid right after capture.
          axiod_d    = beat_of({dest_mac_i, src_mac_i, ethertype_i}, '0);
          axiolast_d = 1'b0;
        end
      end
      StPre, StHdr: begin
        if (accept) begin
          if (axiolast_q) begin
            state_d    = StDone;
            cnt_d      = '0;
            axiov_d    = 1'b0;
            axiod_d    = '0;
            axiolast_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            cnt_d      = cnt_nxt;
            axiod_d    = beat_of(hdr_q, cnt_nxt);
            axiolast_d = (cnt_nxt == LastIdx);
            if (state_q == StPre && cnt_nxt == PreEnd) state_d = StHdr;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hdr_q      <= '0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      axiolast_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      axiolast_q <= axiolast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign axiov_o    = axiov_q;
  assign axiod_o    = axiod_q;
  assign axiolast_o = axiolast_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_eth_header_serializer.sv
module tb_eth_header_serializer;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic        axior;
  logic [47:0] dest, src;
  logic [15:0] et;

  logic       v_a, l_a, busy_a, done_a;
  logic [1:0] d_a;
  logic       v_b, l_b, busy_b, done_b;
  logic [7:0] d_b;

  // Monitor mux: sel=0 watches the dibit/preamble DUT, sel=1 the byte-mode DUT.
  logic       sel;
  logic       mon_v, mon_l, mon_busy, mon_done;
  logic [7:0] mon_d;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_d[$];
  logic       got_l[$];

  logic [7:0] exp_hdr [14] = '{8'h69, 8'h2C, 8'h08, 8'h30, 8'h75, 8'hFD,
                               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h08, 8'h00};

  eth_header_serializer #(.OUT_W(2), .PREAMBLE(1'b1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .dest_mac_i(dest), .src_mac_i(src),
    .ethertype_i(et), .axior_i(axior), .axiov_o(v_a), .axiod_o(d_a), .axiolast_o(l_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  eth_header_serializer #(.OUT_W(8), .PREAMBLE(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .dest_mac_i(dest), .src_mac_i(src),
    .ethertype_i(et), .axior_i(axior), .axiov_o(v_b), .axiod_o(d_b), .axiolast_o(l_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  always_comb begin
    mon_v    = sel ? v_b : v_a;
    mon_d    = sel ? d_b : {6'b0, d_a};
    mon_l    = sel ? l_b : l_a;
    mon_busy = sel ? busy_b : busy_a;
    mon_done = sel ? done_b : done_a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-listed byte stream for OUT_W=2, PREAMBLE=1, sliced into dibits LSB first.
  function automatic logic [7:0] exp_beat_a(input int i);
    logic [7:0] b;
    int bi;
    bi = i / 4;
    if (bi < 7)       b = 8'h55;
    else if (bi == 7) b = 8'hD5;
    else              b = exp_hdr[bi - 8];
    return (b >> (2 * (i % 4))) & 8'h03;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
  endtask

  // Drives axior with stall_pct% low cycles and records every accepted beat. Optionally
  // re-pulses start (and clobbers dest) at beat mid_start_at, or resets at beat reset_at.
  task automatic run(input int stall_pct, input int mid_start_at, input int reset_at,
                     output int ncnt, output bit saw_done, output int gap);
    bit         prev_stall;
    bit         mid_done;
    logic [7:0] prev_d;
    logic       prev_l;
    int         cyc_last;
    prev_stall = 0; mid_done = 0; prev_d = '0; prev_l = 0;
    ncnt = 0; saw_done = 0; gap = -1; cyc_last = -100;
    got_d.delete(); got_l.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (cyc == 0) begin
        check_val("latency_valid", mon_v, 1);
        check_val("latency_busy", mon_busy, 1);
      end
      if (mon_done) begin
        saw_done = 1;
        gap = cyc - cyc_last;
        check_val("busy_low_at_done", mon_busy, 0);
        check_val("valid_low_at_done", mon_v, 0);
        break;
      end
      if (prev_stall) begin
        check_val("stall_data", mon_d, prev_d);
        check_val("stall_valid", mon_v, 1);
        check_val("stall_last", mon_l, prev_l);
      end
      if (ncnt == mid_start_at && !mid_done) begin
        mid_done = 1;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        dest = 48'h0;
      end
      if (ncnt == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", mon_v, 0);
        check_val("rst_mid_data", mon_d, 0);
        check_val("rst_mid_last", mon_l, 0);
        check_val("rst_mid_busy", mon_busy, 0);
        check_val("rst_mid_done", mon_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      axior = ($urandom_range(0, 99) >= stall_pct);
      if (mon_v && axior) begin
        got_d.push_back(mon_d);
        got_l.push_back(mon_l);
        ncnt++;
        cyc_last = cyc;
      end
      prev_stall = mon_v && !axior;
      prev_d     = mon_d;
      prev_l     = mon_l;
    end
  endtask

  task automatic compare_stream_a(input string tag);
    check_val({tag, "_count"}, got_d.size(), 88);
    for (int i = 0; i < got_d.size(); i++) begin
      check_val($sformatf("%s_beat%0d", tag, i), got_d[i], exp_beat_a(i));
      check_val($sformatf("%s_last%0d", tag, i), got_l[i], (i == 87));
    end
  endtask

  initial begin
    int  n;
    bit  sd;
    int  gap;
    bit  any_v;
    rst_n = 1'b1; start_a = 0; start_b = 0; axior = 0; sel = 0;
    dest = 48'h692C083075FD; src = 48'hFFFFFFFFFFFF; et = 16'h0800;

    // Asynchronous reset between edges
    #17 rst_n = 1'b0;
    #1;
    check_val("rst_valid_a", v_a, 0);
    check_val("rst_data_a", d_a, 0);
    check_val("rst_last_a", l_a, 0);
    check_val("rst_busy_a", busy_a, 0);
    check_val("rst_done_a", done_a, 0);
    check_val("rst_valid_b", v_b, 0);
    check_val("rst_data_b", d_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_v = 0;
    repeat (10) begin
      @(negedge clk);
      any_v = any_v | v_a | v_b;
    end
    check_val("idle_no_valid", any_v, 0);

    // Dibit stream with preamble, no stalls
    sel = 0;
    pulse_start();
    run(0, -1, -1, n, sd, gap);
    check_val("a_done_seen", sd, 1);
    check_val("a_done_gap", gap, 1);
    compare_stream_a("nostall");
    if (got_d.size() == 88) begin
      check_val("sfd_b28", got_d[28], 1);
      check_val("sfd_b31", got_d[31], 3);
      check_val("x69_b32", got_d[32], 1);
      check_val("x69_b33", got_d[33], 2);
      check_val("x69_b34", got_d[34], 2);
      check_val("x69_b35", got_d[35], 1);
      check_val("et_b84", got_d[84], 0);
      check_val("last_b87", got_l[87], 1);
    end
    @(negedge clk);
    check_val("done_one_cycle", done_a, 0);

    // Byte mode without preamble
    sel = 1;
    pulse_start();
    run(0, -1, -1, n, sd, gap);
    check_val("b_done_seen", sd, 1);
    check_val("b_count", got_d.size(), 14);
    for (int i = 0; i < got_d.size(); i++) begin
      check_val($sformatf("byte%0d", i), got_d[i], exp_hdr[i]);
      check_val($sformatf("byte_last%0d", i), got_l[i], (i == 13));
    end
    repeat (2) @(negedge clk);

    // Backpressure, 40% ready low
    sel = 0;
    pulse_start();
    run(40, -1, -1, n, sd, gap);
    check_val("bp_done_seen", sd, 1);
    compare_stream_a("stall");
    repeat (2) @(negedge clk);

    // Start re-pulsed mid-header while dest changes
    pulse_start();
    run(0, 20, -1, n, sd, gap);
    check_val("ign_done_seen", sd, 1);
    compare_stream_a("ignstart");
    dest = 48'h692C083075FD;
    repeat (2) @(negedge clk);

    // Reset at beat 40, then a clean restart
    pulse_start();
    run(0, -1, 40, n, sd, gap);
    check_val("rst_beats_before", n, 40);
    repeat (3) @(negedge clk);
    check_val("post_rst_idle", v_a, 0);
    pulse_start();
    run(0, -1, -1, n, sd, gap);
    check_val("rst_done_seen", sd, 1);
    compare_stream_a("afterrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_header_serializer.md
# eth_header_serializer

- Streams the 14-byte Ethernet II header (destination MAC, source MAC, EtherType) onto a narrow MII/RMII-style output. The preamble and SFD can optionally be emitted first.
- Output width is parametrised, and each byte is sent in wire order (LSB first).
- Downstream backpressure uses a valid/ready handshake.
- Position in the packager: ahead of the payload/CRC stages. The frame FSM pulses `start`, and this block returns a `done` pulse when the header has been sent.

## Interface

Parameters:
- `OUT_W`, default 2: beat width in bits; legal values are 1, 2, 4, 8.
- `PREAMBLE`, default 1: when 1, emit 7×0x55 plus SFD 0xD5 before the header; when 0, emit the header only.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to send one header; sampled only in IDLE.
- `dest_mac`, input, 48: destination MAC; byte [47:40] is sent first. Captured when `start` is accepted.
- `src_mac`, input, 48: source MAC; captured when `start` is accepted.
- `ethertype`, input, 16: EtherType; [15:8] is sent first. Captured when `start` is accepted.
- `axior`, input, 1: downstream ready.
- `axiov`, output, 1: beat valid.
- `axiod`, output, `OUT_W`: beat data.
- `axiolast`, output, 1: marks the final header beat.
- `busy`, output, 1: high from start acceptance until the last beat is accepted.
- `done`, output, 1: one-cycle pulse on the cycle after the last beat is accepted.

## Operation

- Byte sequence: [preamble 0x55×7, 0xD5 if `PREAMBLE`], then dest[47:40] through dest[7:0], then src[47:40] through src[7:0], then ethertype[15:8], ethertype[7:0].
- Length: 14 bytes, or 22 with preamble.
- Within a byte, beats run LSB first: beat k carries byte bits [k·OUT_W+OUT_W-1 : k·OUT_W].
  - OUT_W=2 sends bits [1:0], [3:2], [5:4], [7:6].
  - OUT_W=8 sends the byte unchanged.
- Beats per byte BPB = 8/OUT_W. Total beats N = bytes·BPB: 56 (or 88 with preamble) for OUT_W=2.
- The beat counter is $clog2(176)=8 bits wide for every OUT_W. It does not wrap; it returns to 0 only at completion or reset.
- FSM states:
  - IDLE: outputs quiet. `start`=1 captures the fields, clears the beat counter and moves to PRE if `PREAMBLE`=1, otherwise HDR.
  - PRE: beats 0..8·BPB-1 come from the constant preamble/SFD. When the last SFD beat is accepted, move to HDR.
  - HDR: emits the header beats. When the last beat is accepted (`axiov`&`axior`&`axiolast`), move to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
- Handshake:
  - Both the beat and the counter advance only on `axiov`&`axior`.
  - While `axior`=0, `axiod`, `axiov` and `axiolast` hold stable.
  - `axiov` never drops mid-header.
- `start` outside IDLE is ignored, with no queuing. Captured fields are not affected by input changes after capture.
- Reset: asserting `rst` low at any time, including mid-header, immediately and asynchronously drives the state to IDLE. All outputs go to 0 and the counter to 0. No partial header resumes after release.

## Timing

- Reset values: `axiov`=0, `axiod`=0, `axiolast`=0, `busy`=0, `done`=0.
- When `axiov`=0, `axiod` reads 0.
- Latency: `start` is sampled high in IDLE at edge T. From edge T on, `busy`=1, `axiov`=1 and `axiod` carries beat 0.
- With `axior` held at 1, each beat is accepted per clock.
  - The last beat is valid during cycle T+N-1.
  - `done`=1 and `busy`=0 after edge T+N.
  - IDLE is reached after edge T+N+1; the earliest next start is sampled at edge T+N+1.
- `axiolast` is asserted only together with beat N-1.
- All outputs are registered; there is no combinational path from `start` or `axior` to any output.

## Test plan

- Reset state: `rst`=0 pulsed asynchronously between clock edges -> all outputs are 0 immediately. After release, `start`=0 for 10 cycles -> `axiov` stays 0.
- Dibit header, default params (OUT_W=2, PREAMBLE=1), dest=0x692C083075FD, src=0xFFFFFFFFFFFF, ethertype=0x0800, `axior`=1:
  - 88 consecutive beats.
  - Beats 0–27 are 01; beats 28–31 are 01,01,01,11.
  - Beats 32–35 are 01,10,10,01 (byte 0x69).
  - Beats 84–87 are 00,00,00,00, with `axiolast` on beat 87.
  - `done` one cycle later.
- Byte mode without preamble (OUT_W=8, PREAMBLE=0), same fields:
  - `axiod` = 69,2C,08,30,75,FD,FF×6,08,00 over 14 beats.
  - `busy` falls after the 14th accepted beat.
- Backpressure: `axior` random, 40% low -> the beat stream equals the no-stall stream, data stays stable while stalled, and the count of accepted beats is exactly N.
- Ignored start plus input change:
  - `start` pulsed mid-header -> no restart and the beat count is unchanged.
  - dest_mac changed after capture -> the output still carries the captured value.
- Mid-operation reset: `rst` low at beat 40 -> outputs go to 0. After release and a new `start`, the stream begins at beat 0.
